// File: rtl/gdg_pkg.sv
// Shared definitions for the multichannel gate/delay generator.
// Channel state encoding and the default counter width.
package gdg_pkg;

  localparam int GDG_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_GATE  = 2'd2
  } gdg_state_e;

endpackage

// File: rtl/gdg_channel.sv
// One gate/delay channel: IDLE -> DELAY -> GATE sequencer with a saturating
// down-counter, retrigger/overrun handling and a registered output polarity.
module gdg_channel
  import gdg_pkg::*;
#(
  parameter int CNT_W = GDG_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt,
  input  logic             enable,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic             retrig,
  input  logic             invert,
  input  logic             clr_ovr,
  output logic             pulse,
  output logic             busy,
  output logic             overrun
);

  gdg_state_e       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] w_lat, nxt_w;
  logic             set_ovr;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_w     = w_lat;
    set_ovr   = 1'b0;

    case (state)
      ST_DELAY: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - 1'b1;
        end else if (w_lat != '0) begin
          nxt_state = ST_GATE;
          nxt_cnt   = w_lat - 1'b1;
        end else begin
          nxt_state = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (cnt != '0) nxt_cnt = cnt - 1'b1;
        else           nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase

    // An accepted trigger reloads from the live inputs and overrides any
    // completion happening in the same cycle.
    if (evt && enable) begin
      if (state == ST_IDLE || retrig) begin
        nxt_w = width;
        if (delay != '0) begin
          nxt_state = ST_DELAY;
          nxt_cnt   = delay - 1'b1;
        end else if (width != '0) begin
          nxt_state = ST_GATE;
          nxt_cnt   = width - 1'b1;
        end else begin
          nxt_state = ST_IDLE;
        end
      end else begin
        set_ovr = 1'b1;
      end
    end

    if (!enable) nxt_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      w_lat   <= '0;
      pulse   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      w_lat   <= nxt_w;
      busy    <= (nxt_state != ST_IDLE);
      pulse   <= (nxt_state == ST_GATE) ^ invert;
      overrun <= set_ovr | (overrun & ~clr_ovr);
    end
  end

endmodule

// File: rtl/multichannel_gate_delay_gen.sv
// Shared trigger synchroniser and edge detector fanned out to N_CH
// independent gate/delay channels.
module multichannel_gate_delay_gen
  import gdg_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = GDG_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_trigger,
  input  logic [N_CH-1:0]       i_enable,
  input  logic [N_CH*CNT_W-1:0] i_delay,
  input  logic [N_CH*CNT_W-1:0] i_width,
  input  logic [N_CH-1:0]       i_retrig,
  input  logic [N_CH-1:0]       i_invert,
  input  logic                  i_clr_ovr,
  output logic [N_CH-1:0]       o_pulse,
  output logic [N_CH-1:0]       o_busy,
  output logic [N_CH-1:0]       o_overrun,
  output logic                  o_trig_evt
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync       <= '0;
      last       <= 1'b0;
      o_trig_evt <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], i_trigger};
      last       <= sync[SYNC_STAGES-1];
      o_trig_evt <= sync[SYNC_STAGES-1] & ~last;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    gdg_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .evt     (o_trig_evt),
      .enable  (i_enable[k]),
      .delay   (i_delay[k*CNT_W +: CNT_W]),
      .width   (i_width[k*CNT_W +: CNT_W]),
      .retrig  (i_retrig[k]),
      .invert  (i_invert[k]),
      .clr_ovr (i_clr_ovr),
      .pulse   (o_pulse[k]),
      .busy    (o_busy[k]),
      .overrun (o_overrun[k])
    );
  end

endmodule
